// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter onto one req/gnt/rvalid memory port
// Define ARB_RR_EN to replace D-priority with anti-starvation streak by two-way round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                req,
    input  logic                reset,
    input  logic                i_req_in,
    input  logic [ADDR_W-1:0]   i_addr_in,
    output logic                i_gnt_out,
    output logic                i_rvalid_out,
    output logic [DATA_W-1:0]   i_rdata_out,
    input  logic                d_req_in,
    input  logic [ADDR_W-1:0]   d_addr_in,
    input  logic                d_we_in,
    input  logic [DATA_W/8-1:0] d_be_in,
    input  logic [DATA_W-1:0]   d_wdata_in,
    output logic                d_gnt_out,
    output logic                d_rvalid_out,
    output logic [DATA_W-1:0]   d_rdata_out,
    output logic                mem_req_out,
    output logic [ADDR_W-1:0]   mem_addr_out,
    output logic                mem_we_out,
    output logic [DATA_W/8-1:0] mem_be_out,
    output logic [DATA_W-1:0]   mem_wdata_out,
    input  logic                mem_gnt_in,
    input  logic                mem_rvalid_in,
    input  logic [DATA_W-1:0]   mem_rdata_in,
    output logic                busy_out
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;   // 0 = fetch (I), 1 = load/store (D)
    logic   owner_req;
    logic   sel_d;
    logic   take;
    logic   gnt;
    logic   rvalid;

`ifdef ARB_RR_EN
    logic rr_last_q;            // 1 = D was selected last

    always_comb begin
        if (i_req_in && d_req_in) sel_d = ~rr_last_q;
        else                      sel_d = d_req_in;
    end
`else
    logic [3:0] streak_q;       // consecutive D wins while fetch was waiting

    always_comb begin
        if (i_req_in && d_req_in) sel_d = (streak_q != 4'(STARVE_LIMIT));
        else                      sel_d = d_req_in;
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        take        = 1'b0;
        gnt         = 1'b0;
        rvalid      = 1'b0;
        mem_req_out = 1'b0;
        owner_req   = owner_q ? d_req_in : i_req_in;
        case (state_q)
            IDLE: begin
                if (i_req_in || d_req_in) begin
                    take    = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // A requester withdrawing before grant cancels the slot outright.
                if (!owner_req) begin
                    state_d = IDLE;
                end else begin
                    mem_req_out = 1'b1;
                    if (mem_gnt_in) begin
                        gnt = 1'b1;
                        if (mem_rvalid_in) begin
                            rvalid  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (mem_rvalid_in) begin
                    rvalid = 1'b1;
                    if (i_req_in || d_req_in) begin
                        take    = 1'b1;
                        state_d = ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) owner_d = sel_d;
    end

    assign i_gnt_out     = gnt & ~owner_q;
    assign d_gnt_out     = gnt & owner_q;
    assign i_rvalid_out  = rvalid & ~owner_q;
    assign d_rvalid_out  = rvalid & owner_q;
    assign i_rdata_out   = mem_rdata_in;
    assign d_rdata_out   = mem_rdata_in;
    assign busy_out      = (state_q != IDLE);

    // Fetch never writes, so it presents a full-word read.
    assign mem_addr_out  = mem_req_out ? (owner_q ? d_addr_in : i_addr_in) : '0;
    assign mem_we_out    = mem_req_out & owner_q & d_we_in;
    assign mem_be_out    = mem_req_out ? (owner_q ? d_be_in : '1) : '0;
    assign mem_wdata_out = (mem_req_out && owner_q) ? d_wdata_in : '0;

    always_ff @(posedge req) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
`ifdef ARB_RR_EN
            rr_last_q <= 1'b1;
`else
            streak_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (take) begin
`ifdef ARB_RR_EN
                rr_last_q <= sel_d;
`else
                streak_q  <= (sel_d && i_req_in) ? streak_q + 4'd1 : 4'd0;
`endif
            end
        end
    end

endmodule
